// File: rtl/uart_core_pkg.sv
// -----------------------------------------------------------------------------
// uart_core_pkg
// Shared definitions for the UART core and the ring-buffer peripheral that
// drives it: RX state encoding, 8N1 frame length and a constant log2 helper.
// No ports.
// -----------------------------------------------------------------------------
package uart_core_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous rxpin into the clk domain through a SYNC_STAGES flop
// chain and keeps the synced value seen on the previous bitxce tick, so the RX
// engine can detect a falling edge between two consecutive ticks.
// Ports:
//   i_clk        system clock
//   i_reset      asynchronous active-high reset (all flops go to line-idle 1)
//   i_bitxce     oversample tick strobe
//   i_rxpin      asynchronous serial input
//   o_line       synchronized line value
//   o_prev_line  synchronized line value captured on the previous tick
// -----------------------------------------------------------------------------
module uart_rx_sync
   import uart_core_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_bitxce,
   input  logic i_rxpin,
   output logic o_line,
   output logic o_prev_line
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // The synchronizer runs every clk; only the edge register is tick-gated.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxpin};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_prev <= 1'b1;
      end else if (i_bitxce) begin
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_line      = r_sync[SYNC_STAGES-1];
   assign o_prev_line = r_prev;

endmodule

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// 8N1 UART transceiver timed by an external oversample strobe (OVERSAMPLE
// ticks per bit). TX serializes one byte per accepted load; RX deserializes
// the synchronized rxpin, sampling mid-bit.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   bitxce     oversample strobe, one clk wide
//   txpin      serial output, idle high
//   load, d    send request and byte (honoured only while txbusy=0)
//   txbusy     high from the cycle after accept until the end of the stop bit
//   rxpin      asynchronous serial input
//   bytercvd   one-clk pulse when q holds a new byte
//   q          last received byte
//   frame_err  one-clk pulse when a stop bit is sampled low
//   rxst       RX state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// -----------------------------------------------------------------------------
module uart_core
   import uart_core_pkg::*;
#(
   parameter int OVERSAMPLE  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bitxce,
   output logic       txpin,
   input  logic       load,
   input  logic [7:0] d,
   output logic       txbusy,
   input  logic       rxpin,
   output logic       bytercvd,
   output logic [7:0] q,
   output logic       frame_err,
   output logic [1:0] rxst
);

   localparam int             TW          = clog2(OVERSAMPLE);
   localparam logic [TW-1:0]  TICK_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0]  TICK_MID    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]     TX_LAST_BIT = 4'(FRAME_BITS - 1);

   // ---------------- TX engine ----------------
   logic                  r_txpin;
   logic                  r_txbusy;
   logic [FRAME_BITS-1:0] r_txsr;
   logic [TW-1:0]         r_txtick;
   logic [3:0]            r_txbit;

   // The whole frame (start, data, stop) is preloaded into a shift register;
   // each bit is driven on the first tick of its period. txbusy is a flop so
   // the upstream pointer update sees a clean falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_txpin  <= 1'b1;
         r_txbusy <= 1'b0;
         r_txsr   <= '1;
         r_txtick <= '0;
         r_txbit  <= '0;
      end else if (!r_txbusy) begin
         if (load) begin
            r_txsr   <= {1'b1, d, 1'b0};
            r_txbusy <= 1'b1;
            r_txtick <= '0;
            r_txbit  <= '0;
         end
      end else if (bitxce) begin
         if (r_txtick == '0) r_txpin <= r_txsr[0];
         r_txtick <= r_txtick + 1'b1;
         if (r_txtick == TICK_LAST) begin
            r_txsr  <= {1'b1, r_txsr[FRAME_BITS-1:1]};
            r_txbit <= r_txbit + 1'b1;
            // Release on the last stop-bit tick so a new load can start the
            // next frame on the very next tick (no extra idle bit).
            if (r_txbit == TX_LAST_BIT) r_txbusy <= 1'b0;
         end
      end
   end

   // ---------------- RX engine ----------------
   logic w_line;
   logic w_prev_line;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx_sync (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_bitxce    (bitxce),
      .i_rxpin     (rxpin),
      .o_line      (w_line),
      .o_prev_line (w_prev_line)
   );

   rx_state_t     r_rxst;
   logic [TW-1:0] r_rxtick;
   logic [3:0]    r_rxbit;
   logic [7:0]    r_rxsr;
   logic [7:0]    r_q;
   logic          r_bytercvd;
   logic          r_frame_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxst      <= RX_IDLE;
         r_rxtick    <= '0;
         r_rxbit     <= '0;
         r_rxsr      <= '0;
         r_q         <= '0;
         r_bytercvd  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_bytercvd  <= 1'b0;
         r_frame_err <= 1'b0;
         if (bitxce) begin
            case (r_rxst)
               RX_IDLE: begin
                  // Needs a high-to-low transition, so a held-low break
                  // cannot retrigger after a framing error.
                  if (!w_line && w_prev_line) begin
                     r_rxst   <= RX_START;
                     r_rxtick <= '0;
                  end
               end
               RX_START: begin
                  r_rxtick <= r_rxtick + 1'b1;
                  if (r_rxtick == TICK_MID) begin
                     if (w_line) begin
                        r_rxst <= RX_IDLE;
                     end else begin
                        r_rxst   <= RX_DATA;
                        r_rxtick <= '0;
                        r_rxbit  <= '0;
                     end
                  end
               end
               RX_DATA: begin
                  r_rxtick <= r_rxtick + 1'b1;
                  if (r_rxtick == TICK_LAST) begin
                     r_rxsr  <= {w_line, r_rxsr[7:1]};
                     r_rxbit <= r_rxbit + 1'b1;
                     if (r_rxbit == 4'd7) r_rxst <= RX_STOP;
                  end
               end
               RX_STOP: begin
                  r_rxtick <= r_rxtick + 1'b1;
                  if (r_rxtick == TICK_LAST) begin
                     if (w_line) begin
                        r_q        <= r_rxsr;
                        r_bytercvd <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                     r_rxst <= RX_IDLE;
                  end
               end
               default: r_rxst <= RX_IDLE;
            endcase
         end
      end
   end

   assign txpin     = r_txpin;
   assign txbusy    = r_txbusy;
   assign bytercvd  = r_bytercvd;
   assign q         = r_q;
   assign frame_err = r_frame_err;
   assign rxst      = r_rxst;

endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core
// Directed bench for uart_core with a frame-level TX model and an RX event
// scoreboard checked every clk, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_core;

   localparam int OS      = 8;
   localparam int BIT_CLK = 13 * OS;   // 104 clk per bit
   localparam int TRACE_N = 1100;

   logic       clk;
   logic       reset;
   logic       bitxce;
   logic       txpin;
   logic       load;
   logic [7:0] d;
   logic       txbusy;
   logic       rxpin;
   logic       bytercvd;
   logic [7:0] q;
   logic       frame_err;
   logic [1:0] rxst;

   int total = 0;
   int bad   = 0;

   uart_core #(
      .OVERSAMPLE (OS),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bitxce   (bitxce),
      .txpin    (txpin),
      .load     (load),
      .d        (d),
      .txbusy   (txbusy),
      .rxpin    (rxpin),
      .bytercvd (bytercvd),
      .q        (q),
      .frame_err(frame_err),
      .rxst     (rxst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oversample strobe: one clk high every 13 clk.
   initial begin
      bitxce = 1'b0;
      forever begin
         repeat (12) @(negedge clk);
         bitxce = 1'b1;
         @(negedge clk);
         bitxce = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- TX model: ticks elapsed since the accepted load ----------
   logic       m_busy;
   int         m_n;
   logic [9:0] m_frame;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_n     <= 0;
         m_frame <= 10'h3FF;
      end else if (!m_busy) begin
         if (load) begin
            m_busy  <= 1'b1;
            m_n     <= 0;
            m_frame <= {1'b1, d, 1'b0};
         end
      end else if (bitxce) begin
         m_n <= m_n + 1;
         if (m_n + 1 == 10 * OS) m_busy <= 1'b0;
      end
   end

   // Tick n (1-based) of a frame drives frame bit (n-1)/OS; before the first
   // tick the line is idle, after the last it stays at the stop level.
   function automatic logic exp_txpin();
      if (m_n >= 1 && m_n <= 10 * OS) return m_frame[(m_n - 1) / OS];
      return 1'b1;
   endfunction

   // ---------------- RX scoreboard: queued byte values, 256 = framing error ---
   int         exp_ev[$];
   logic [7:0] m_q;

   initial begin
      m_q = 8'h00;
      forever begin
         step();
         if (reset) begin
            m_q = 8'h00;
         end else begin
            check("rx_single_pulse_kind", {31'b0, bytercvd & frame_err}, 0);
            if (bytercvd) begin
               check("rx_byte_expected", {31'b0, exp_ev.size() > 0 && exp_ev[0] != 256}, 1);
               if (exp_ev.size() > 0 && exp_ev[0] != 256) begin
                  check("rx_q_value", {24'b0, q}, exp_ev[0]);
                  m_q = 8'(exp_ev[0]);
                  void'(exp_ev.pop_front());
               end
            end
            if (frame_err) begin
               check("rx_ferr_expected", {31'b0, exp_ev.size() > 0 && exp_ev[0] == 256}, 1);
               if (exp_ev.size() > 0 && exp_ev[0] == 256) void'(exp_ev.pop_front());
            end
         end
         check("rx_q_hold", {24'b0, q}, {24'b0, m_q});
         check("tx_busy_model", {31'b0, txbusy}, {31'b0, m_busy});
         check("tx_pin_model", {31'b0, txpin}, {31'b0, exp_txpin()});
      end
   end

   // ---------------- stimulus helpers ----------------
   logic tr_pin  [TRACE_N];
   logic tr_busy [TRACE_N];

   task automatic do_load(input logic [7:0] v);
      @(negedge clk);
      load = 1'b1;
      d    = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_tx_fall();
      int n = 0;
      while (txpin !== 1'b0 && n < 3000) begin
         step();
         n++;
      end
      check("tx_start_timeout", {31'b0, txpin}, 0);
   endtask

   task automatic wait_tx_idle();
      int n = 0;
      while (txbusy !== 1'b0 && n < 3000) begin
         step();
         n++;
      end
      check("tx_done_timeout", {31'b0, txbusy}, 0);
   endtask

   // Sample k of the trace is k clk after the first sample with txpin low.
   task automatic capture();
      wait_tx_fall();
      for (int k = 0; k < TRACE_N; k++) begin
         if (k > 0) step();
         tr_pin[k]  = txpin;
         tr_busy[k] = txbusy;
      end
   endtask

   function automatic logic [7:0] decode_trace();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = tr_pin[BIT_CLK / 2 + BIT_CLK * (i + 1)];
      return b;
   endfunction

   task automatic send_rx(input logic [7:0] b, input logic stop, input int nbits);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      if (nbits == 10) exp_ev.push_back(stop ? int'(b) : 256);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         rxpin = fr[i];
         repeat (BIT_CLK - 1) @(negedge clk);
      end
   endtask

   task automatic wait_events();
      int n = 0;
      while (exp_ev.size() > 0 && n < 3000) begin
         step();
         n++;
      end
      check("rx_event_timeout", exp_ev.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [9:0] exp55;
      int         saw_start;
      int         max_st;
      int         retrig;

      reset = 1'b1;
      load  = 1'b0;
      d     = 8'h00;
      rxpin = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_txpin", {31'b0, txpin}, 1);
      check("rst_txbusy", {31'b0, txbusy}, 0);
      check("rst_bytercvd", {31'b0, bytercvd}, 0);
      check("rst_frame_err", {31'b0, frame_err}, 0);
      check("rst_q", {24'b0, q}, 0);
      check("rst_rxst", {30'b0, rxst}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // TX 0x55: alternating line, 104 clk bits, txbusy low 1027 clk after start.
      do_load(8'h55);
      capture();
      exp55 = 10'b1010101010;
      for (int j = 0; j < 10; j++)
         check($sformatf("tx55_bit%0d", j), {31'b0, tr_pin[BIT_CLK / 2 + BIT_CLK * j]}, {31'b0, exp55[j]});
      check("tx55_start_last", {31'b0, tr_pin[103]}, 0);
      check("tx55_d0_first", {31'b0, tr_pin[104]}, 1);
      check("tx55_busy_before_fall", {31'b0, tr_busy[1026]}, 1);
      check("tx55_busy_fall", {31'b0, tr_busy[1027]}, 0);
      check("tx55_idle_after", {31'b0, tr_pin[1099]}, 1);
      repeat (30) step();

      // TX 0xA3 with an ignored 0xFF load, then 0x0F loaded the first idle cycle.
      do_load(8'hA3);
      fork
         capture();
         begin
            int n = 0;
            repeat (300) @(negedge clk);
            load = 1'b1;
            d    = 8'hFF;
            @(negedge clk);
            load = 1'b0;
            while (txbusy && n < 3000) begin
               step();
               n++;
            end
            load = 1'b1;
            d    = 8'h0F;
            step();
            load = 1'b0;
         end
      join
      check("txa3_start", {31'b0, tr_pin[52]}, 0);
      check("txa3_data", {24'b0, decode_trace()}, 32'hA3);
      check("txa3_stop", {31'b0, tr_pin[988]}, 1);
      check("txa3_stop_end", {31'b0, tr_pin[1039]}, 1);
      check("tx_b2b_next_start", {31'b0, tr_pin[1040]}, 0);
      wait_tx_idle();
      repeat (30) step();

      // RX 0x3C then 0xA5, q holds between frames.
      send_rx(8'h3C, 1'b1, 10);
      wait_events();
      check("rx3c_rxst_idle", {30'b0, rxst}, 0);
      check("rx3c_q", {24'b0, q}, 32'h3C);
      repeat (400) step();
      check("rx3c_q_still", {24'b0, q}, 32'h3C);
      send_rx(8'hA5, 1'b1, 10);
      wait_events();
      check("rxa5_q", {24'b0, q}, 32'hA5);
      repeat (50) step();

      // 30 clk low glitch: false start only.
      saw_start = 0;
      max_st    = 0;
      step();
      rxpin = 1'b0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (k == 29) rxpin = 1'b1;
         if (rxst == 2'd1) saw_start = 1;
         if (int'(rxst) > max_st) max_st = int'(rxst);
      end
      check("rx_glitch_start_seen", saw_start, 1);
      check("rx_glitch_max_state", max_st, 1);
      check("rx_glitch_rxst_idle", {30'b0, rxst}, 0);
      check("rx_glitch_q", {24'b0, q}, 32'hA5);

      // 0x81 with low stop bit, then a 2000 clk break: one frame_err, no retrigger.
      send_rx(8'h81, 1'b0, 10);
      retrig = 0;
      for (int k = 0; k < 2000; k++) begin
         step();
         if (rxst != 2'd0) retrig++;
      end
      check("rx_break_no_retrigger", retrig, 0);
      wait_events();
      check("rx_ferr_q_unchanged", {24'b0, q}, 32'hA5);
      @(negedge clk);
      rxpin = 1'b1;
      repeat (50) step();
      send_rx(8'h5A, 1'b1, 10);
      wait_events();
      check("rx_rearm_q", {24'b0, q}, 32'h5A);
      repeat (30) step();

      // Reset during bit 4 of both a TX and an RX frame.
      fork
         do_load(8'hC5);
         send_rx(8'h3A, 1'b1, 5);
      join
      check("mid_txbusy", {31'b0, txbusy}, 1);
      check("mid_rxst_data", {30'b0, rxst}, 2);
      @(negedge clk);
      reset = 1'b1;
      rxpin = 1'b1;
      #1;
      check("abort_txpin", {31'b0, txpin}, 1);
      check("abort_txbusy", {31'b0, txbusy}, 0);
      check("abort_rxst", {30'b0, rxst}, 0);
      check("abort_bytercvd", {31'b0, bytercvd}, 0);
      check("abort_q", {24'b0, q}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (30) step();

      // Full frames after the abort.
      fork
         capture();
         do_load(8'h96);
         send_rx(8'h69, 1'b1, 10);
      join
      check("post_tx_data", {24'b0, decode_trace()}, 32'h96);
      wait_events();
      wait_tx_idle();
      check("post_rx_q", {24'b0, q}, 32'h69);
      check("post_rxst_idle", {30'b0, rxst}, 0);
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
